// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: InstMemory address/data, decode valid/ready handshake
// and branch/jump redirect. The fetch controller uses the master modport.
interface inst_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] instAddr;
  logic [DATA_W-1:0] instMem;
  logic [DATA_W-1:0] instOut;
  logic [ADDR_W-1:0] pcOut;
  logic              instValid;
  logic              decReady;
  logic              redirect;
  logic [ADDR_W-1:0] redirectAddr;

  modport master (
    output instAddr,
    input  instMem,
    output instOut,
    output pcOut,
    output instValid,
    input  decReady,
    input  redirect,
    input  redirectAddr
  );

  modport slave (
    input  instAddr,
    output instMem,
    input  instOut,
    input  pcOut,
    input  instValid,
    output decReady,
    output redirect,
    output redirectAddr
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for a combinational-read instruction memory with a 2-entry buffer.
// Optional accepted-instruction counter enabled by defining FETCH_COUNT_EN.
module inst_fetch_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = 8'h00,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  inst_fetch_if.master bus,
  output logic         busy,
  output logic         done,
  output logic [15:0]  fetchCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] r_buf_inst [2];
  logic [ADDR_W-1:0] r_buf_pc   [2];
  logic              r_head;
  logic              w_head_nxt;
  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  logic              r_done;
  logic              w_done_nxt;

  logic              w_redirect;
  logic              w_pop_req;
  logic              w_pop;
  logic              w_push;
  logic              w_halt;
  logic              w_tail;
  logic              w_valid;
  logic [ADDR_W-1:0] w_redirect_pc;

  // Buffer bookkeeping. A pop request at count 2 frees the slot being written,
  // so a push can land there on the same edge without losing order.
  always_comb begin
    w_redirect    = bus.redirect && (r_state != S_IDLE);
    w_redirect_pc = bus.redirectAddr & ~ADDR_W'(3);
    w_valid       = (r_count != 2'd0);
    w_pop_req     = w_valid && bus.decReady;
    w_pop         = w_pop_req && !w_redirect;
    w_push        = (r_state == S_FETCH) && ((r_count != 2'd2) || w_pop_req) && !w_redirect;
    w_halt        = (bus.instMem == HALT_WORD);
    w_tail        = r_head ^ r_count[0];

    if (w_redirect) begin
      w_count_nxt = 2'd0;
      w_head_nxt  = 1'b0;
    end else begin
      w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
      w_head_nxt  = r_head ^ w_pop;
    end
  end

  // NOTE: every next-state signal gets its default first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_done_nxt  = 1'b0;

    if (w_redirect) begin
      w_state_nxt = S_FETCH;
      w_pc_nxt    = w_redirect_pc;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = BOOT_ADDR;
          end
        end
        S_FETCH: begin
          if (w_push) begin
            if (w_halt) begin
              w_state_nxt = S_DRAIN;
            end else begin
              w_pc_nxt = r_pc + ADDR_W'(4);
            end
          end
        end
        S_DRAIN: begin
          if (w_count_nxt == 2'd0) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= BOOT_ADDR;
      r_head  <= 1'b0;
      r_count <= 2'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_head  <= w_head_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // NOTE: buffer storage is not reset; its contents only reach the outputs
  // while the count says the slot is occupied, so reset-time values never matter.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[w_tail] <= bus.instMem;
      r_buf_pc[w_tail]   <= r_pc;
    end
  end

  assign bus.instAddr  = r_pc;
  assign bus.instValid = w_valid;
  assign bus.instOut   = w_valid ? r_buf_inst[r_head] : '0;
  assign bus.pcOut     = w_valid ? r_buf_pc[r_head]   : '0;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

`ifdef FETCH_COUNT_EN
  // Counts decode acceptances; a redirect survives it, a new start clears it.
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= 16'h0000;
    end else if ((r_state == S_IDLE) && start) begin
      r_fetch_count <= 16'h0000;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetchCount = r_fetch_count;
`else
  assign fetchCount = 16'h0000;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus randomized
// programs, scored against a program-order stream model of expected fetches.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] fetchCount;
  logic [31:0] mem [64];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: the next address decode should see, in program order
  logic [7:0]  exp_pc;
  logic [15:0] exp_count;

  inst_fetch_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  inst_fetch_ctrl #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .BOOT_ADDR(8'h00),
    .HALT_WORD(HALT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .fetchCount(fetchCount)
  );

  assign bus.instMem = mem[bus.instAddr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_fc();
`ifdef FETCH_COUNT_EN
    return exp_count;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start     = 1'b0;
    exp_pc    = 8'h00;
    exp_count = 16'h0000;
    check("start_busy", busy, 1'b1);
    check("start_valid", bus.instValid, 1'b0);
    check("start_addr", bus.instAddr, 8'h00);
  endtask

  // One clock with the given decode/redirect inputs; scores any accepted head.
  task automatic cycle(input logic dr, input logic rd, input logic [7:0] ra);
    logic        pop;
    logic        hold;
    logic        done_exp;
    logic [7:0]  hold_pc;
    logic [31:0] hold_inst;
    pop       = dr && !rd && bus.instValid;
    hold      = bus.instValid && !dr && !rd;
    hold_pc   = bus.pcOut;
    hold_inst = bus.instOut;
    done_exp  = 1'b0;
    if (pop) begin
      check("head_pc", bus.pcOut, exp_pc);
      check("head_inst", bus.instOut, mem[exp_pc[7:2]]);
      done_exp  = (mem[exp_pc[7:2]] == HALT);
      exp_pc    = exp_pc + 8'd4;
      exp_count = exp_count + 16'd1;
    end
    if (rd) exp_pc = ra & 8'hFC;
    bus.decReady     = dr;
    bus.redirect     = rd;
    bus.redirectAddr = ra;
    tick();
    bus.redirect = 1'b0;
    check("done", done, done_exp);
    if (done_exp) begin
      check("idle_busy", busy, 1'b0);
      check("idle_valid", bus.instValid, 1'b0);
    end
    if (rd) begin
      check("redir_valid", bus.instValid, 1'b0);
      check("redir_addr", bus.instAddr, ra & 8'hFC);
      check("redir_busy", busy, 1'b1);
    end
    if (hold) begin
      check("stable_pc", bus.pcOut, hold_pc);
      check("stable_inst", bus.instOut, hold_inst);
    end
    check("fetch_count", fetchCount, exp_fc());
  endtask

  task automatic run_until_idle(input logic rnd);
    logic idle;
    logic dr;
    logic rd;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && !bus.instValid) begin
        idle = 1'b1;
        break;
      end
      dr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd = rnd && ($urandom_range(0, 15) == 0);
      cycle(dr, rd, 8'($urandom));
    end
    check("run_timeout", idle, 1'b1);
    cycle(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    rst              = 1'b1;
    start            = 1'b0;
    bus.decReady     = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirectAddr = 8'h00;
    exp_pc           = 8'h00;
    exp_count        = 16'h0000;
    for (int i = 0; i < 64; i++) mem[i] = 32'h13000000 | 32'(i);
    mem[0]  = 32'h20080005;
    mem[1]  = 32'h20090003;
    mem[2]  = HALT;
    mem[9]  = HALT;
    mem[63] = 32'h0000AAAA;

    #12;
    check("rst_valid", bus.instValid, 1'b0);
    check("rst_inst", bus.instOut, 32'h0);
    check("rst_pc", bus.pcOut, 8'h00);
    check("rst_addr", bus.instAddr, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fc", fetchCount, 16'h0000);
    rst = 1'b0;
    tick();

    // Straight-line program ending in a halt word, decode always ready
    do_start();
    cycle(1'b1, 1'b0, 8'h00);
    check("t1_valid", bus.instValid, 1'b1);
    check("t1_pc", bus.pcOut, 8'h00);
    check("t1_inst", bus.instOut, 32'h20080005);
    run_until_idle(1'b0);
    check("t1_fc", fetchCount, exp_fc());

    // Backpressure: buffer fills and PC stalls on the third word
    do_start();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
    check("t2_addr", bus.instAddr, 8'h08);
    check("t2_inst", bus.instOut, 32'h20080005);
    check("t2_pc", bus.pcOut, 8'h00);
    run_until_idle(1'b0);

    // Redirect with a full buffer and a same-edge accept
    do_start();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h22);
    cycle(1'b0, 1'b0, 8'h00);
    check("t3_valid", bus.instValid, 1'b1);
    check("t3_pc", bus.pcOut, 8'h20);
    run_until_idle(1'b0);

    // Redirect racing a pop at count 1: the pop is discarded
    do_start();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h20);
    run_until_idle(1'b0);

    // PC wrap from the top word back to address 0
    do_start();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'hFC);
    cycle(1'b1, 1'b0, 8'h00);
    check("t4_pc_fc", bus.pcOut, 8'hFC);
    check("t4_addr_wrap", bus.instAddr, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("t4_pc_00", bus.pcOut, 8'h00);
    run_until_idle(1'b0);

    // Asynchronous reset between edges in the middle of a run
    do_start();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("t5_valid", bus.instValid, 1'b0);
    check("t5_inst", bus.instOut, 32'h0);
    check("t5_pc", bus.pcOut, 8'h00);
    check("t5_addr", bus.instAddr, 8'h00);
    check("t5_busy", busy, 1'b0);
    check("t5_fc", fetchCount, 16'h0000);
    rst       = 1'b0;
    exp_count = 16'h0000;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
    check("t5_still_idle", busy, 1'b0);
    check("t5_addr_hold", bus.instAddr, 8'h00);
    do_start();
    run_until_idle(1'b0);

    // Random programs with random backpressure and redirects
    for (int run = 0; run < 20; run++) begin
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      mem[63] = HALT;
      do_start();
      run_until_idle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
